// File: rtl/rst_sequencer.sv
// Staged reset controller: asynchronous assertion, ordered synchronous release, sticky cause record.
// Optional watchdog self-reset is built when RST_SEQ_WDT_EN is defined.
module rst_sequencer #(
    parameter int NUM_STAGES   = 4,
    parameter int STAGE_CYCLES = 16,
    parameter int NUM_REQ      = 3,
    parameter int SYNC_DEPTH   = 2,
    parameter int WDT_CYCLES   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  wdt_kick,
    input  logic                  cause_clr,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready,
    output logic [NUM_REQ+1:0]    cause
);
    localparam int CNT_W = $clog2(STAGE_CYCLES + 1);
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [NUM_REQ+1:0] CAUSE_POR = {{(NUM_REQ+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_t;

    state_t                state, state_next;
    logic [SYNC_DEPTH-1:0] sync;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [NUM_STAGES-1:0] stages_next;
    logic                  ready_next;
    logic [NUM_REQ+1:0]    cause_next;
    logic [NUM_REQ+1:0]    set_bits;
    logic                  wdt_evt;
    logic                  restart;
    logic                  running;

`ifdef RST_SEQ_WDT_EN
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdt_cnt;

    // Watchdog only counts while sitting in DONE; any exit or kick restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
        end else if (state != DONE || wdt_kick || restart) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end

    assign wdt_evt = (state == DONE) && !wdt_kick && (wdt_cnt == WDT_LAST);
`else
    logic [WDT_W:0] unused_wdt;
    assign unused_wdt = {{WDT_W{1'b0}}, wdt_kick};
    assign wdt_evt    = 1'b0;
`endif

    assign set_bits = {wdt_evt, req, 1'b0};
    assign restart  = (|req) || wdt_evt;
    assign running  = sync[SYNC_DEPTH-1] && !restart;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        stages_next = stage_rst_n;
        ready_next  = ready;
        cause_next  = cause_clr ? set_bits : (cause | set_bits);

        if (restart) begin
            state_next  = HOLD;
            cnt_next    = '0;
            stages_next = '0;
            ready_next  = 1'b0;
        end else if (running) begin
            case (state)
                HOLD, RELEASE: begin
                    if (state == RELEASE && (&stage_rst_n)) begin
                        state_next = DONE;
                        ready_next = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        // Gap elapsed: release the next stage index and reload.
                        state_next  = RELEASE;
                        cnt_next    = '0;
                        stages_next = (stage_rst_n << 1) | NUM_STAGES'(1);
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= '0;
            state       <= HOLD;
            cnt         <= '0;
            stage_rst_n <= '0;
            ready       <= 1'b0;
            cause       <= CAUSE_POR;
        end else begin
            sync        <= {sync[SYNC_DEPTH-2:0], 1'b1};
            state       <= state_next;
            cnt         <= cnt_next;
            stage_rst_n <= stages_next;
            ready       <= ready_next;
            cause       <= cause_next;
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed steps plus randomized requests, checked against an
// edge-time reference model (release times derived from the latest restart anchor).
module tb_rst_sequencer;
    localparam int NS = 3;
    localparam int SC = 4;
    localparam int NR = 3;
    localparam int SD = 2;
    localparam int WC = 8;
    localparam int FAR = -1000000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req;
    logic          wdt_kick;
    logic          cause_clr;
    logic [NS-1:0] stage_rst_n;
    logic          ready;
    logic [NR+1:0] cause;

    rst_sequencer #(
        .NUM_STAGES  (NS),
        .STAGE_CYCLES(SC),
        .NUM_REQ     (NR),
        .SYNC_DEPTH  (SD),
        .WDT_CYCLES  (WC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .wdt_kick   (wdt_kick),
        .cause_clr  (cause_clr),
        .stage_rst_n(stage_rst_n),
        .ready      (ready),
        .cause      (cause)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: edge numbers of the synchronizer release (t_edge), the latest
    // restart event (e_edge) and the latest watchdog kick seen in DONE (kick_edge).
    int            rise_edges;
    int            t_edge;
    int            e_edge;
    int            kick_edge;
    logic [NR+1:0] m_cause;

    function automatic int anchor();
        return (t_edge > e_edge) ? t_edge : e_edge;
    endfunction

    function automatic bit synced();
        return (rst_n === 1'b1) && (rise_edges >= SD);
    endfunction

    task automatic reset_model();
        rise_edges = 0;
        t_edge     = FAR;
        e_edge     = FAR;
        kick_edge  = FAR;
        m_cause    = {{(NR+1){1'b0}}, 1'b1};
    endtask

    task automatic edge_model();
        logic wdt;
        int   r;
        int   base;
        cyc++;
        if (rst_n !== 1'b1) return;
        wdt = 1'b0;
`ifdef RST_SEQ_WDT_EN
        if (synced()) begin
            r    = anchor() + NS * SC + 1;
            base = (kick_edge > r) ? kick_edge : r;
            if (wdt_kick && cyc > r) kick_edge = cyc;
            else if (cyc == base + WC) wdt = 1'b1;
        end
`else
        r    = 0;
        base = 0;
`endif
        m_cause = cause_clr ? {wdt, req, 1'b0} : (m_cause | {wdt, req, 1'b0});
        if (rise_edges < SD) begin
            rise_edges++;
            if (rise_edges == SD) t_edge = cyc;
        end
        if ((|req) || wdt) e_edge = cyc;
    endtask

    task automatic check(input string tag);
        logic [NS-1:0] es;
        logic          er;
        int            el;
        int            k;
        es = '0;
        er = 1'b0;
        if (synced()) begin
            el = cyc - anchor();
            k  = el / SC;
            if (k > NS) k = NS;
            es = NS'((1 << k) - 1);
            er = (el >= NS * SC + 1);
        end
        n_cmp++;
        assert (stage_rst_n === es) else begin
            n_bad++;
            $error("FAIL %s stage_rst_n got %b want %b (cyc %0d)", tag, stage_rst_n, es, cyc);
        end
        n_cmp++;
        assert (ready === er) else begin
            n_bad++;
            $error("FAIL %s ready got %b want %b (cyc %0d)", tag, ready, er, cyc);
        end
        n_cmp++;
        assert (cause === m_cause) else begin
            n_bad++;
            $error("FAIL %s cause got %h want %h (cyc %0d)", tag, cause, m_cause, cyc);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        edge_model();
        #1;
        check(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        wdt_kick  = 1'b0;
        cause_clr = 1'b0;
        reset_model();

        // Power-on
        run(3, "por_hold");
        rst_n = 1'b1;
        run(20, "por_release");

        // Single-cycle request in DONE
        req = 3'b010;
        step("req1_pulse");
        req = '0;
        run(16, "req1_rerelease");

        // Held request during RELEASE
        req = 3'b010;
        step("req1_again");
        req = '0;
        run(5, "into_release");
        req = 3'b001;
        run(10, "req0_held");
        req = '0;
        run(20, "req0_drop");

        // Cause clear coinciding with a request
        req       = 3'b100;
        cause_clr = 1'b1;
        step("clr_with_req2");
        req       = '0;
        cause_clr = 1'b0;
        run(16, "after_clr");

        // Randomized quiet/burst phases
        for (int it = 0; it < 14; it++) begin
            int quiet;
            int burst;
            quiet = $urandom_range(0, 20);
            for (int i = 0; i < quiet; i++) begin
                cause_clr = ($urandom_range(0, 7) == 0);
                wdt_kick  = ($urandom_range(0, 2) == 0);
                step("rand_quiet");
            end
            cause_clr = 1'b0;
            wdt_kick  = 1'b0;
            burst = $urandom_range(1, 4);
            for (int i = 0; i < burst; i++) begin
                req       = NR'($urandom_range(1, 7));
                cause_clr = ($urandom_range(0, 3) == 0);
                step("rand_burst");
            end
            req       = '0;
            cause_clr = 1'b0;
        end
        run(16, "rand_settle");

        // Asynchronous reset between edges with stage 1 released
        req = 3'b001;
        step("pre_async_req");
        req = '0;
        run(8, "pre_async");
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        check("async_assert");
        run(2, "async_hold");
        rst_n = 1'b1;
        run(20, "async_release");

`ifdef RST_SEQ_WDT_EN
        run(30, "wdt_nokick");
        for (int i = 0; i < 60; i++) begin
            wdt_kick = (i % 5 == 0);
            step("wdt_kicked");
        end
        wdt_kick = 1'b0;
        run(12, "wdt_stop_kick");
`else
        wdt_kick = 1'b1;
        run(20, "kick_ignored");
        wdt_kick = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
